pipeline_chroma_key_config: RTL and testbench
=============================================

# pipeline_chroma_key_config

Configuration controller for the chroma-key stage of the pixel pipeline. Accepts a byte-wide command stream from the host command decoder and parses it into shadow registers for the key thresholds and key enable. Commits the shadow set atomically into the active registers that drive the chroma-key comparator, either at the next frame boundary or immediately on command, so a frame is never keyed with a half-updated threshold set.

## Interface
Parameters:
- R_WIDTH, 5, red channel width
- G_WIDTH, 6, green channel width
- B_WIDTH, 5, blue channel width
- RED_DEFAULT, 5'd4, reset value of red maximum
- GREEN_DEFAULT, 6'd44, reset value of green minimum
- BLUE_DEFAULT, 5'd12, reset value of blue maximum

Ports:
- clk  in  1  pixel clock; one clock only
- rst  in  1  reset, asynchronous, active-high
- cmd_data  in  8  command/payload byte
- cmd_valid  in  1  cmd_data valid
- cmd_ready  out  1  byte accepted when cmd_valid && cmd_ready
- cmd_abort  in  1  discard partial command, e.g. host chip-select released
- frame_start  in  1  one-cycle pulse at first pixel of frame
- key_enable  out  1  active enable to the keyer
- key_red_max  out  R_WIDTH  active red upper bound
- key_green_min  out  G_WIDTH  active green lower bound
- key_blue_max  out  B_WIDTH  active blue upper bound
- cfg_pending  out  1  shadow differs from active (written, not committed)
- cfg_error  out  1  sticky: unknown opcode seen

## Operation
- Opcodes:
  - 0x10 SET_THRESH: 3 payload bytes R, G, B; the low R/G/B_WIDTH bits are used and upper bits are ignored.
  - 0x11 SET_ENABLE: 1 payload byte; bit0 is the enable.
  - 0x12 COMMIT_NOW: no payload.
  - 0x13 CLEAR_ERROR: no payload.
- FSM states:
  - IDLE: a handshaked byte is an opcode.
    - 0x10/0x11: load payload count (3/1) and go to PAYLOAD.
    - 0x12/0x13: go to APPLY.
    - Unknown opcode: set cfg_error, stay in IDLE, byte dropped.
  - PAYLOAD: each handshaked byte goes into payload buffer slot[cnt]. On the last byte, go to APPLY.
  - APPLY: one cycle, cmd_ready=0.
    - SET_*: write the shadow and set pending.
    - COMMIT_NOW: active <= shadow, clear pending.
    - CLEAR_ERROR: clear cfg_error.
    - Then go to IDLE.
- cmd_ready is 1 in IDLE and PAYLOAD, 0 in APPLY and during reset.
- frame_start with pending=1: active <= shadow, pending <= 0.
- frame_start with pending=0: no change.
- Simultaneous events:
  - APPLY(SET_*) and frame_start in the same cycle: active takes the pre-update shadow; the new shadow is written; pending stays 1, so the new values commit at the following frame.
  - APPLY(COMMIT_NOW) and frame_start in the same cycle: single commit, pending 0.
- cmd_abort:
  - Any state returns to IDLE next cycle.
  - A partial payload is discarded; shadow and pending are unchanged.
  - An abort during APPLY wins: the APPLY action is not performed.
  - cmd_abort takes priority over a same-cycle cmd_valid.
- Reset values:
  - Active and shadow = defaults, key_enable=0.
  - pending=0, cfg_error=0, FSM=IDLE, cmd_ready=0 while rst=1.

## Timing
- Last payload byte handshaked in cycle N: APPLY in N+1; shadow/cfg_pending visible in N+2.
- COMMIT_NOW handshaked in N: active outputs change in N+2.
- frame_start in cycle F: active outputs carry the new values from F+1. The downstream keyer must tolerate that the first pixel of the frame still uses the previous set.
- Throughput: SET_THRESH occupies 5 cycles minimum (4 bytes + APPLY).
- Outputs are registered; there is no combinational path from any input to any output except none.

## Structure
- Shared package (pipeline_pkg):
  - Opcode constants CMD_SET_THRESH, CMD_SET_ENABLE, CMD_COMMIT_NOW, CMD_CLEAR_ERROR.
  - FSM state enum.
  - Default threshold constants, shared with the keyer.
- No sub-module is needed. The parser FSM, shadow bank and active bank stay in one module; the keyer is instantiated by the pipeline top, not here.

## Test plan
- Reset: after rst pulse, outputs are 4/44/12, key_enable=0, cfg_pending=0, cfg_error=0; cmd_ready=0 during rst and 1 one cycle after release.
- Frame-boundary commit:
  - Stimulus: SET_THRESH 0x03,0x30,0x08, then SET_ENABLE 0x01.
  - Required: cfg_pending=1 and active outputs unchanged until frame_start; from frame_start+1, outputs are 3/48/8, enable=1, pending=0.
- Race with frame_start: frame_start coincident with APPLY of SET_THRESH 0x1F,0x3F,0x1F. Active must take the old shadow and pending must stay 1. The next frame_start must apply 31/63/31.
- Abort: SET_THRESH 0x01,0x02 then cmd_abort. Shadow must be unchanged and pending unchanged. The next byte 0x12 must be treated as an opcode.
- Error and clear:
  - Opcode 0x7E: cfg_error=1, no state change; the following SET_ENABLE 0x01 is parsed normally.
  - CLEAR_ERROR: cfg_error=0 two cycles after its handshake.
- Backpressure and COMMIT_NOW:
  - Hold cmd_valid high across a 4-byte command followed by 0x12. Each byte is accepted exactly once, cmd_ready drops for the APPLY cycle, and active updates at N+2 after 0x12 with no frame_start.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pixel pipeline: command opcodes, parser states
// and the chroma-key threshold defaults that the keyer also relies on.
package pipeline_pkg;

    localparam logic [7:0] CMD_SET_THRESH  = 8'h10;
    localparam logic [7:0] CMD_SET_ENABLE  = 8'h11;
    localparam logic [7:0] CMD_COMMIT_NOW  = 8'h12;
    localparam logic [7:0] CMD_CLEAR_ERROR = 8'h13;

    localparam logic [4:0] DEF_RED_MAX   = 5'd4;
    localparam logic [5:0] DEF_GREEN_MIN = 6'd44;
    localparam logic [4:0] DEF_BLUE_MAX  = 5'd12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_chroma_key_config_if.sv
// Byte-wide command stream from the host command decoder.
interface pipeline_chroma_key_config_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_abort;

    modport master (output cmd_data, output cmd_valid, output cmd_abort, input cmd_ready);
    modport slave  (input cmd_data, input cmd_valid, input cmd_abort, output cmd_ready);
endinterface

// File: rtl/pipeline_chroma_key_config.sv
// Chroma-key configuration: parses host commands into a shadow bank and commits
// it atomically to the active bank at a frame boundary or on COMMIT_NOW.
module pipeline_chroma_key_config
    import pipeline_pkg::*;
#(
    parameter int                 R_WIDTH       = 5,
    parameter int                 G_WIDTH       = 6,
    parameter int                 B_WIDTH       = 5,
    parameter logic [R_WIDTH-1:0] RED_DEFAULT   = DEF_RED_MAX,
    parameter logic [G_WIDTH-1:0] GREEN_DEFAULT = DEF_GREEN_MIN,
    parameter logic [B_WIDTH-1:0] BLUE_DEFAULT  = DEF_BLUE_MAX
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_chroma_key_config_if.slave  cmd,
    input  logic                         frame_start,
    output logic                         key_enable,
    output logic [R_WIDTH-1:0]           key_red_max,
    output logic [G_WIDTH-1:0]           key_green_min,
    output logic [B_WIDTH-1:0]           key_blue_max,
    output logic                         cfg_pending,
    output logic                         cfg_error
);

    state_t       state_reg, state_next;
    logic [1:0]   cnt_reg, cnt_next;
    logic [7:0]   opcode_reg, opcode_next;
    logic         ready_reg, ready_next;
    logic         err_set;
    logic         hs;
    logic         last_byte;
    logic [7:0]   pbuf_reg [3];

    logic               sh_en_reg, act_en_reg;
    logic [R_WIDTH-1:0] sh_r_reg, act_r_reg;
    logic [G_WIDTH-1:0] sh_g_reg, act_g_reg;
    logic [B_WIDTH-1:0] sh_b_reg, act_b_reg;
    logic               pending_reg, error_reg;

    logic apply_fire, commit_now, set_thr, set_en;
    logic unused_payload;

    // Abort outranks a same-cycle byte, so it also blocks the handshake.
    assign hs        = cmd.cmd_valid && ready_reg && !cmd.cmd_abort;
    assign last_byte = (opcode_reg == CMD_SET_THRESH) ? (cnt_reg == 2'd2) : (cnt_reg == 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= 2'd0;
            opcode_reg <= 8'h00;
            ready_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            opcode_reg <= opcode_next;
            ready_reg  <= ready_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        opcode_next = opcode_reg;
        err_set     = 1'b0;
        if (cmd.cmd_abort) begin
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (hs) begin
                        cnt_next = 2'd0;
                        case (cmd.cmd_data)
                            CMD_SET_THRESH, CMD_SET_ENABLE: begin
                                opcode_next = cmd.cmd_data;
                                state_next  = ST_PAYLOAD;
                            end
                            CMD_COMMIT_NOW, CMD_CLEAR_ERROR: begin
                                opcode_next = cmd.cmd_data;
                                state_next  = ST_APPLY;
                            end
                            default: err_set = 1'b1;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (hs) begin
                        cnt_next = cnt_reg + 2'd1;
                        if (last_byte) begin
                            state_next = ST_APPLY;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
        ready_next = (state_next != ST_APPLY);
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pbuf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pbuf_reg[gi] <= 8'h00;
                end else if (state_reg == ST_PAYLOAD && hs && cnt_reg == 2'(gi)) begin
                    pbuf_reg[gi] <= cmd.cmd_data;
                end
            end
        end
    endgenerate

    // Upper payload bits beyond the channel widths are intentionally dropped.
    assign unused_payload = ^{pbuf_reg[0], pbuf_reg[1], pbuf_reg[2]};

    assign apply_fire = (state_reg == ST_APPLY) && !cmd.cmd_abort;
    assign commit_now = apply_fire && (opcode_reg == CMD_COMMIT_NOW);
    assign set_thr    = apply_fire && (opcode_reg == CMD_SET_THRESH);
    assign set_en     = apply_fire && (opcode_reg == CMD_SET_ENABLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en_reg   <= 1'b0;
            sh_r_reg    <= RED_DEFAULT;
            sh_g_reg    <= GREEN_DEFAULT;
            sh_b_reg    <= BLUE_DEFAULT;
            act_en_reg  <= 1'b0;
            act_r_reg   <= RED_DEFAULT;
            act_g_reg   <= GREEN_DEFAULT;
            act_b_reg   <= BLUE_DEFAULT;
            pending_reg <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            if (err_set) begin
                error_reg <= 1'b1;
            end else if (apply_fire && opcode_reg == CMD_CLEAR_ERROR) begin
                error_reg <= 1'b0;
            end
            // Active always takes the pre-update shadow, even when a SET lands
            // in the same cycle; that SET then stays pending for the next frame.
            if (commit_now || (frame_start && pending_reg)) begin
                act_en_reg <= sh_en_reg;
                act_r_reg  <= sh_r_reg;
                act_g_reg  <= sh_g_reg;
                act_b_reg  <= sh_b_reg;
            end
            if (set_thr) begin
                sh_r_reg <= pbuf_reg[0][R_WIDTH-1:0];
                sh_g_reg <= pbuf_reg[1][G_WIDTH-1:0];
                sh_b_reg <= pbuf_reg[2][B_WIDTH-1:0];
            end
            if (set_en) begin
                sh_en_reg <= pbuf_reg[0][0];
            end
            if (set_thr || set_en) begin
                pending_reg <= 1'b1;
            end else if (commit_now || frame_start) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign cmd.cmd_ready   = ready_reg;
    assign key_enable      = act_en_reg;
    assign key_red_max     = act_r_reg;
    assign key_green_min   = act_g_reg;
    assign key_blue_max    = act_b_reg;
    assign cfg_pending     = pending_reg;
    assign cfg_error       = error_reg;

endmodule

// File: tb/tb_pipeline_chroma_key_config.sv
// Directed bench for the chroma-key configuration block with a queue of
// expected active-bank values popped after each commit event.
module tb_pipeline_chroma_key_config;
    import pipeline_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic frame_start;
    logic key_enable;
    logic [4:0] key_red_max;
    logic [5:0] key_green_min;
    logic [4:0] key_blue_max;
    logic cfg_pending;
    logic cfg_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    pipeline_chroma_key_config_if cif ();

    pipeline_chroma_key_config dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cif.slave),
        .frame_start  (frame_start),
        .key_enable   (key_enable),
        .key_red_max  (key_red_max),
        .key_green_min(key_green_min),
        .key_blue_max (key_blue_max),
        .cfg_pending  (cfg_pending),
        .cfg_error    (cfg_error)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic en, input logic [4:0] r,
                                       input logic [5:0] g, input logic [4:0] b);
        return {15'd0, en, r, g, b};
    endfunction

    function automatic logic [31:0] act();
        return mk(key_enable, key_red_max, key_green_min, key_blue_max);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, act(), e.val);
        end
    endtask

    // Returns at the negedge following the posedge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        logic ok;
        int   budget;
        budget = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = b;
        do begin
            ok = cif.cmd_ready;
            step();
            budget++;
        end while (!ok && budget < 20);
        cif.cmd_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    logic [7:0] bp_bytes [5];
    logic       ready_seen [8];
    int         bp_cycles;
    int         bp_idx;

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        cif.cmd_valid = 1'b0;
        cif.cmd_data  = 8'h00;
        cif.cmd_abort = 1'b0;
        step();
        step();
        chk("ready_in_reset", 32'(cif.cmd_ready), 32'd0);
        chk("reset_active", act(), mk(1'b0, 5'd4, 6'd44, 5'd12));
        chk("reset_pending", 32'(cfg_pending), 32'd0);
        chk("reset_error", 32'(cfg_error), 32'd0);
        rst = 1'b0;
        step();
        chk("ready_after_reset", 32'(cif.cmd_ready), 32'd1);
        $display("reset done");

        // Frame-boundary commit
        send_byte(CMD_SET_THRESH);
        send_byte(8'h03);
        send_byte(8'h30);
        send_byte(8'h08);
        chk("apply_ready_low", 32'(cif.cmd_ready), 32'd0);
        step();
        chk("thr_pending", 32'(cfg_pending), 32'd1);
        chk("thr_active_hold", act(), mk(1'b0, 5'd4, 6'd44, 5'd12));
        send_byte(CMD_SET_ENABLE);
        send_byte(8'h01);
        step();
        chk("en_active_hold", act(), mk(1'b0, 5'd4, 6'd44, 5'd12));
        push_exp("frame_commit", mk(1'b1, 5'd3, 6'd48, 5'd8));
        pulse_frame();
        pop_chk();
        chk("frame_pending_clr", 32'(cfg_pending), 32'd0);
        $display("frame commit 3/48/8 en=1");

        // Race between APPLY(SET_THRESH) and frame_start
        send_byte(CMD_SET_ENABLE);
        send_byte(8'h00);
        step();
        send_byte(CMD_SET_THRESH);
        send_byte(8'h1F);
        send_byte(8'h3F);
        send_byte(8'h1F);
        push_exp("race_old_shadow", mk(1'b0, 5'd3, 6'd48, 5'd8));
        pulse_frame();
        pop_chk();
        chk("race_pending_kept", 32'(cfg_pending), 32'd1);
        step();
        push_exp("race_next_frame", mk(1'b0, 5'd31, 6'd63, 5'd31));
        pulse_frame();
        pop_chk();
        chk("race_pending_clr", 32'(cfg_pending), 32'd0);
        $display("race handled 31/63/31");

        // Abort a partial SET_THRESH, with a same-cycle byte that must be ignored
        send_byte(CMD_SET_THRESH);
        send_byte(8'h01);
        send_byte(8'h02);
        cif.cmd_abort = 1'b1;
        cif.cmd_valid = 1'b1;
        cif.cmd_data  = 8'h05;
        step();
        cif.cmd_abort = 1'b0;
        cif.cmd_valid = 1'b0;
        chk("abort_pending", 32'(cfg_pending), 32'd0);
        chk("abort_ready", 32'(cif.cmd_ready), 32'd1);
        send_byte(CMD_COMMIT_NOW);
        step();
        push_exp("abort_commit", mk(1'b0, 5'd31, 6'd63, 5'd31));
        pop_chk();
        chk("abort_commit_pending", 32'(cfg_pending), 32'd0);
        chk("abort_no_error", 32'(cfg_error), 32'd0);
        $display("abort discarded partial payload");

        // Unknown opcode, then normal parsing, then CLEAR_ERROR
        send_byte(8'h7E);
        chk("err_set", 32'(cfg_error), 32'd1);
        chk("err_no_pending", 32'(cfg_pending), 32'd0);
        chk("err_ready", 32'(cif.cmd_ready), 32'd1);
        send_byte(CMD_SET_ENABLE);
        send_byte(8'h01);
        step();
        chk("err_then_parse", 32'(cfg_pending), 32'd1);
        send_byte(CMD_CLEAR_ERROR);
        chk("clr_err_n1", 32'(cfg_error), 32'd1);
        step();
        chk("clr_err_n2", 32'(cfg_error), 32'd0);
        $display("error set and cleared");

        // Back-to-back bytes with cmd_valid held; upper payload bits must be ignored
        bp_bytes[0] = CMD_SET_THRESH;
        bp_bytes[1] = 8'hEA;
        bp_bytes[2] = 8'hD5;
        bp_bytes[3] = 8'hE7;
        bp_bytes[4] = CMD_COMMIT_NOW;
        bp_idx    = 0;
        bp_cycles = 0;
        cif.cmd_valid = 1'b1;
        while (bp_idx < 5 && bp_cycles < 8) begin
            cif.cmd_data = bp_bytes[bp_idx];
            ready_seen[bp_cycles] = cif.cmd_ready;
            step();
            if (ready_seen[bp_cycles]) bp_idx++;
            bp_cycles++;
        end
        cif.cmd_valid = 1'b0;
        chk("bp_cycles", 32'(bp_cycles), 32'd6);
        chk("bp_apply_ready", 32'(ready_seen[4]), 32'd0);
        chk("bp_ready_pattern", {28'd0, ready_seen[0], ready_seen[1], ready_seen[2], ready_seen[3]}, 32'hF);
        chk("bp_commit_n1", act(), mk(1'b0, 5'd31, 6'd63, 5'd31));
        step();
        push_exp("bp_commit_n2", mk(1'b1, 5'd10, 6'd21, 5'd7));
        pop_chk();
        chk("bp_pending", 32'(cfg_pending), 32'd0);
        $display("commit_now 10/21/7 en=1");

        // Idle frame_start must not disturb the active bank
        push_exp("idle_frame", mk(1'b1, 5'd10, 6'd21, 5'd7));
        pulse_frame();
        pop_chk();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
